// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with show-ahead head
// output, back-pressure via full_F and a single-cycle flush on branch redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_F,
    input  logic [ADDR_W-1:0]          pc_F,
    input  logic [INSTR_W-1:0]         instr_F,
    input  logic                       flush,
    input  logic                       pop_D,
    output logic                       valid_D,
    output logic [ADDR_W-1:0]          pc_D,
    output logic [INSTR_W-1:0]         instr_D,
    output logic                       full_F,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    fq_entry_t         head;

    // Status comes from the registered count only, so push/pop never feed back combinationally.
    assign valid_D = (count != '0);
    assign full_F  = (count == CW'(DEPTH));
    assign push_ok = push_F && !full_F;
    assign pop_ok  = pop_D && valid_D;

    assign head    = mem[rd_ptr];
    assign pc_D    = head.pc;
    assign instr_D = head.instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{pc: pc_F, instr: instr_F};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;
    import fetch_pkg::*;

    logic               clk;
    logic               reset;
    logic               push_F;
    logic [63:0]        pc_F;
    logic [31:0]        instr_F;
    logic               flush;
    logic               pop_D;
    logic               valid_D;
    logic [63:0]        pc_D;
    logic [31:0]        instr_D;
    logic               full_F;
    logic [2:0]         count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .push_F  (push_F),
        .pc_F    (pc_F),
        .instr_F (instr_F),
        .flush   (flush),
        .pop_D   (pop_D),
        .valid_D (valid_D),
        .pc_D    (pc_D),
        .instr_D (instr_D),
        .full_F  (full_F),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_F = 1'b0;
        pop_D  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic push(input logic [63:0] pc);
        push_F  = 1'b1;
        pc_F    = pc;
        instr_F = 32'h9100_0000 | pc[31:0];
    endtask

    initial begin
        reset = 1'b1;
        idle();
        pc_F = '0;
        instr_F = '0;
        #2;
        chk("rst_valid", 64'(valid_D), 64'h0);
        chk("rst_full",  64'(full_F),  64'h0);
        chk("rst_count", 64'(count),   64'h0);
        chk("rst_pc",    pc_D,         64'h0);
        chk("rst_instr", 64'(instr_D), 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // single push
        push_F = 1'b1; pc_F = 64'h0; instr_F = 32'h8B02_0020;
        tick();
        idle();
        chk("one_valid", 64'(valid_D), 64'h1);
        chk("one_pc",    pc_D,         64'h0);
        chk("one_instr", 64'(instr_D), 64'h8B02_0020);
        chk("one_count", 64'(count),   64'h1);
        pop_D = 1'b1;
        tick();
        idle();
        chk("one_popped", 64'(valid_D), 64'h0);

        // fill to full, overflow ignored, drain in order
        for (int i = 0; i < 4; i++) begin
            push(64'(4 * i));
            tick();
        end
        idle();
        chk("fill_full",  64'(full_F), 64'h1);
        chk("fill_count", 64'(count),  64'h4);
        push(64'h10);
        tick();
        idle();
        chk("ovf_count", 64'(count), 64'h4);
        chk("ovf_head",  pc_D,       64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",    pc_D,         64'(4 * i));
            chk("drain_instr", 64'(instr_D), 64'(32'h9100_0000 | 32'(4 * i)));
            pop_D = 1'b1;
            tick();
            chk("drain_full", 64'(full_F), 64'h0);
        end
        idle();
        chk("drain_valid", 64'(valid_D), 64'h0);
        chk("drain_count", 64'(count),   64'h0);

        // streaming push+pop across pointer wrap
        push(64'h0);
        tick();
        for (int k = 1; k < 10; k++) begin
            chk("stream_pc", pc_D, 64'(4 * (k - 1)));
            push(64'(4 * k));
            pop_D = 1'b1;
            tick();
            chk("stream_count", 64'(count), 64'h1);
        end
        idle();
        chk("stream_last", pc_D, 64'h24);
        pop_D = 1'b1;
        tick();
        idle();
        chk("stream_empty", 64'(valid_D), 64'h0);

        // flush beats a same-cycle push
        push(64'h100); tick();
        push(64'h104); tick();
        push(64'h108); tick();
        chk("pre_flush_count", 64'(count), 64'h3);
        push(64'h40);
        flush = 1'b1;
        tick();
        idle();
        chk("flush_count", 64'(count),   64'h0);
        chk("flush_valid", 64'(valid_D), 64'h0);
        chk("flush_full",  64'(full_F),  64'h0);
        push(64'h80);
        tick();
        idle();
        chk("post_flush_pc",    pc_D,       64'h80);
        chk("post_flush_count", 64'(count), 64'h1);
        pop_D = 1'b1;
        tick();
        idle();

        // full: push blocked even with same-cycle pop
        for (int i = 0; i < 4; i++) begin
            push(64'(64'h200 + 4 * i));
            tick();
        end
        idle();
        chk("full2_full", 64'(full_F), 64'h1);
        push(64'h300);
        pop_D = 1'b1;
        tick();
        idle();
        chk("pp_count", 64'(count),  64'h3);
        chk("pp_full",  64'(full_F), 64'h0);
        for (int i = 1; i < 4; i++) begin
            chk("pp_drain", pc_D, 64'(64'h200 + 4 * i));
            pop_D = 1'b1;
            tick();
        end
        idle();
        chk("pp_empty", 64'(valid_D), 64'h0);

        // asynchronous reset between edges
        push(64'h500); tick();
        push(64'h504); tick();
        idle();
        chk("prerst_count", 64'(count), 64'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(count),   64'h0);
        chk("arst_valid", 64'(valid_D), 64'h0);
        chk("arst_pc",    pc_D,         64'h0);
        chk("arst_instr", 64'(instr_D), 64'h0);
        #1;
        reset = 1'b0;
        tick();
        chk("arst_stay_empty", 64'(valid_D), 64'h0);
        push(64'h600);
        tick();
        idle();
        chk("arst_new_pc",    pc_D,       64'h600);
        chk("arst_new_count", 64'(count), 64'h1);
        pop_D = 1'b1;
        tick();
        idle();
        chk("arst_no_old", 64'(valid_D), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode in the pipelined LEGv8 core. Each cycle fetch may push the fetched `{PC, instruction}` pair, and decode pops it when ready. The block decouples a decode stall from fetch by back-pressuring fetch through `full_F`. A branch redirect flushes all buffered wrong-path entries.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `push_F`  in  1  fetch offers an entry this cycle.
- `pc_F`  in  64  PC of the offered instruction (`imem_addr_F`).
- `instr_F`  in  32  instruction word from instruction memory.
- `flush`  in  1  branch taken (`PCSrc`); discard all entries.
- `pop_D`  in  1  decode consumes the head entry this cycle.
- `valid_D`  out  1  head entry present.
- `pc_D`  out  64  PC of the head entry.
- `instr_D`  out  32  instruction of the head entry.
- `full_F`  out  1  queue full; fetch must hold its PC.
- `count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

## Operation
- Storage is a circular array of `DEPTH` entries.
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo `DEPTH`.
  - A separate `count` register tracks occupancy.
- Push is accepted when `push_F && !full_F`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- A push while full is ignored. There is no push-through-on-pop when full: `full_F` blocks the push even if `pop_D` is high in the same cycle.
- Pop is accepted when `pop_D && valid_D`, then `rd_ptr` increments. A pop while empty is ignored.
- Count update per cycle:
  - push only: +1.
  - pop only: −1.
  - both accepted: unchanged.
  - neither: unchanged.
- `valid_D = (count != 0)` and `full_F = (count == DEPTH)`. Both are decoded from registered `count`, so there is no combinational path from `push_F` or `pop_D`.
- `pc_D` and `instr_D` are a show-ahead read of `mem[rd_ptr]`. They are meaningful only while `valid_D` is high.
- `flush` has the highest priority:
  - On the next edge, `wr_ptr`, `rd_ptr` and `count` all go to 0.
  - A push or pop in the same cycle has no effect.
- Reset (asynchronous):
  - `count = 0`, `wr_ptr = 0`, `rd_ptr = 0`.
  - All storage entries are cleared to 0.
  - Resulting outputs: `valid_D = 0`, `full_F = 0`, `pc_D = 0`, `instr_D = 0`, `count = 0`.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Push-to-visible latency is 1 cycle. An entry pushed into an empty queue at edge N is on `valid_D`, `pc_D` and `instr_D` after edge N.
- Pop effect is 1 cycle: the next entry, or `valid_D = 0`, appears after the edge.
- `full_F` asserts in the cycle after the `DEPTH`-th un-popped push. It deasserts in the cycle after the first pop.
- A flush at edge N gives `valid_D = 0` and `full_F = 0` after edge N. Fetch may push again in the cycle after edge N.
- Throughput is one push and one pop per cycle in steady state (0 < count < DEPTH).

## Structure
- A shared package `fetch_pkg` holds:
  - `ADDR_W = 64` and `INSTR_W = 32`.
  - typedef struct `fq_entry_t {logic [63:0] pc; logic [31:0] instr;}`.
- Storage is an array of `fq_entry_t` inside the module.
- Pointer and count logic is a single `always_ff` with asynchronous reset. No sub-module is needed.

## Test plan
- Reset, then one push (`pc_F = 0x0`, `instr_F = 0x8B020020`) → next cycle `valid_D = 1`, `pc_D = 0x0`, `instr_D = 0x8B020020`, `count = 1`.
- Four pushes (PC 0x0, 0x4, 0x8, 0xC) with `pop_D = 0` → `full_F = 1`, `count = 4`. A fifth push (PC 0x10) is ignored. Four pops then return 0x0, 0x4, 0x8, 0xC in order, and `valid_D` falls after the last.
- Continuous push and pop for 10 cycles (PC 0x0..0x24) starting from count = 1 → `count` stays 1. The PCs come out in order across pointer wrap-around with no gap.
- Three entries buffered, then `flush = 1` together with `push_F = 1` (PC 0x40) → next cycle `count = 0`, `valid_D = 0`, and 0x40 is not stored. The following push (PC 0x80) appears at the head.
- Queue full, then `pop_D = 1` and `push_F = 1` in the same cycle → only the pop takes effect, `count = 3`, `full_F = 0`.
- `reset` pulsed between clock edges while `count = 2` → outputs go to 0 immediately, and the pre-reset entries never reappear.
